// File: rtl/mc_sched_pkg.sv
// Shared types and defaults for the Monte Carlo option scheduler.
package mc_sched_pkg;

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_RUN  = 2'd1,
    G_HOLD = 2'd2
  } gen_state_t;

  typedef enum logic {
    C_IDLE = 1'b0,
    C_RUN  = 1'b1
  } core_state_t;

  localparam int unsigned WDOG_CYCLES_DEF = 65535;

endpackage

// File: rtl/mc_rr_select.sv
// Round-robin instance select: modulo-N counter that is held at zero
// whenever its generator group is not busy. Requires N >= 2.
module mc_rr_select #(
  parameter int unsigned N = 3,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_sel
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= '0;
    end else if (i_clr) begin
      r_sel <= '0;
    end else if (i_inc) begin
      r_sel <= (r_sel == LAST) ? '0 : r_sel + W'(1);
    end
  end

  assign o_sel = r_sel;

endmodule

// File: rtl/mc_option_scheduler.sv
// Option sequencer: table generation, bank swap and MC core launch/collect.
// Optional per-stage watchdog is compiled in with SCHED_WATCHDOG_EN.
module mc_option_scheduler
  import mc_sched_pkg::*;
#(
  parameter int unsigned N_GEN       = 3,
  parameter int unsigned N_CORE      = 2,
  parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                     CLK,
  input  logic                     iRstN,
  input  logic                     iOptValid,
  output logic                     oOptReady,
  output logic                     oStartExpMu,
  output logic                     oStartExpSigma,
  input  logic                     iDoneExpMu,
  input  logic                     iDoneExpSigma,
  output logic                     oBusyExpMu,
  output logic                     oBusyExpSigma,
  output logic [$clog2(N_GEN)-1:0] oMuSel,
  output logic [$clog2(N_GEN)-1:0] oSigmaSel,
  output logic                     oSwitch,
  output logic                     oStartCores,
  input  logic [N_CORE-1:0]        iDoneCore,
  output logic                     oBusyCores,
  output logic                     oResultValid,
  output logic                     oResultBank,
  output logic                     oError
);

  gen_state_t  r_gen_state, w_gen_state_next;
  core_state_t r_core_state, w_core_state_next;

  logic r_opt_ready, w_opt_ready_next;
  logic r_start_mu, w_start_mu_next;
  logic r_start_sig, w_start_sig_next;
  logic r_busy_mu, w_busy_mu_next;
  logic r_busy_sig, w_busy_sig_next;
  logic r_mu_flag, w_mu_flag_next;
  logic r_sig_flag, w_sig_flag_next;
  logic r_switch, w_switch_next;
  logic r_bank, w_bank_next;
  logic r_start_cores, w_start_cores_next;
  logic r_busy_cores, w_busy_cores_next;
  logic r_result_valid, w_result_valid_next;
  logic r_error, w_error_next;
  logic [N_CORE-1:0] r_core_flags, w_core_flags_next;

  logic              w_mu_seen, w_sig_seen, w_handoff;
  logic              w_gen_tmo, w_core_tmo;
  logic [N_CORE-1:0] w_core_done_in, w_core_flags_all;

  assign w_mu_seen  = r_mu_flag | iDoneExpMu;
  assign w_sig_seen = r_sig_flag | iDoneExpSigma;
  assign w_handoff  = (r_gen_state == G_HOLD) && (r_core_state == C_IDLE);
  // Core dones coinciding with the start pulse belong to the previous run.
  assign w_core_done_in   = r_start_cores ? '0 : iDoneCore;
  assign w_core_flags_all = r_core_flags | w_core_done_in;

  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      r_gen_state    <= G_IDLE;
      r_core_state   <= C_IDLE;
      r_opt_ready    <= 1'b1;
      r_start_mu     <= 1'b0;
      r_start_sig    <= 1'b0;
      r_busy_mu      <= 1'b0;
      r_busy_sig     <= 1'b0;
      r_mu_flag      <= 1'b0;
      r_sig_flag     <= 1'b0;
      r_switch       <= 1'b0;
      r_bank         <= 1'b0;
      r_start_cores  <= 1'b0;
      r_busy_cores   <= 1'b0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_core_flags   <= '0;
    end else begin
      r_gen_state    <= w_gen_state_next;
      r_core_state   <= w_core_state_next;
      r_opt_ready    <= w_opt_ready_next;
      r_start_mu     <= w_start_mu_next;
      r_start_sig    <= w_start_sig_next;
      r_busy_mu      <= w_busy_mu_next;
      r_busy_sig     <= w_busy_sig_next;
      r_mu_flag      <= w_mu_flag_next;
      r_sig_flag     <= w_sig_flag_next;
      r_switch       <= w_switch_next;
      r_bank         <= w_bank_next;
      r_start_cores  <= w_start_cores_next;
      r_busy_cores   <= w_busy_cores_next;
      r_result_valid <= w_result_valid_next;
      r_error        <= w_error_next;
      r_core_flags   <= w_core_flags_next;
    end
  end

  always_comb begin
    w_gen_state_next    = r_gen_state;
    w_core_state_next   = r_core_state;
    w_opt_ready_next    = r_opt_ready;
    w_start_mu_next     = 1'b0;
    w_start_sig_next    = 1'b0;
    w_busy_mu_next      = r_busy_mu;
    w_busy_sig_next     = r_busy_sig;
    w_mu_flag_next      = r_mu_flag;
    w_sig_flag_next     = r_sig_flag;
    w_switch_next       = r_switch;
    w_bank_next         = r_bank;
    w_start_cores_next  = 1'b0;
    w_busy_cores_next   = r_busy_cores;
    w_result_valid_next = 1'b0;
    w_error_next        = r_error;
    w_core_flags_next   = r_core_flags;

    case (r_gen_state)
      G_IDLE: begin
        if (iOptValid && r_opt_ready) begin
          w_start_mu_next  = 1'b1;
          w_start_sig_next = 1'b1;
          w_busy_mu_next   = 1'b1;
          w_busy_sig_next  = 1'b1;
          w_opt_ready_next = 1'b0;
          w_mu_flag_next   = 1'b0;
          w_sig_flag_next  = 1'b0;
          w_gen_state_next = G_RUN;
        end
      end
      G_RUN: begin
        w_mu_flag_next  = w_mu_seen;
        w_sig_flag_next = w_sig_seen;
        if (iDoneExpMu)    w_busy_mu_next  = 1'b0;
        if (iDoneExpSigma) w_busy_sig_next = 1'b0;
        // A completion on the timeout edge still counts as a success.
        if (w_mu_seen && w_sig_seen) begin
          w_gen_state_next = G_HOLD;
        end else if (w_gen_tmo) begin
          w_busy_mu_next   = 1'b0;
          w_busy_sig_next  = 1'b0;
          w_mu_flag_next   = 1'b0;
          w_sig_flag_next  = 1'b0;
          w_opt_ready_next = 1'b1;
          w_error_next     = 1'b1;
          w_gen_state_next = G_IDLE;
        end
      end
      G_HOLD: begin
        if (w_handoff) begin
          w_opt_ready_next = 1'b1;
          w_gen_state_next = G_IDLE;
        end
      end
      default: w_gen_state_next = G_IDLE;
    endcase

    case (r_core_state)
      C_IDLE: begin
        if (w_handoff) begin
          w_switch_next      = ~r_switch;
          w_bank_next        = r_switch;
          w_start_cores_next = 1'b1;
          w_busy_cores_next  = 1'b1;
          w_core_flags_next  = '0;
          w_core_state_next  = C_RUN;
        end
      end
      C_RUN: begin
        w_core_flags_next = w_core_flags_all;
        if (&w_core_flags_all) begin
          w_busy_cores_next   = 1'b0;
          w_result_valid_next = 1'b1;
          w_core_flags_next   = '0;
          w_core_state_next   = C_IDLE;
        end else if (w_core_tmo) begin
          w_busy_cores_next = 1'b0;
          w_core_flags_next = '0;
          w_error_next      = 1'b1;
          w_core_state_next = C_IDLE;
        end
      end
      default: w_core_state_next = C_IDLE;
    endcase
  end

`ifdef SCHED_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);

  logic [31:0] r_gen_wdog, r_core_wdog;

  // Counters sit at zero outside their RUN state, so every entry restarts them.
  always_ff @(posedge CLK or negedge iRstN) begin
    if (!iRstN) begin
      r_gen_wdog  <= '0;
      r_core_wdog <= '0;
    end else begin
      r_gen_wdog  <= (r_gen_state == G_RUN)  ? r_gen_wdog + 32'd1  : '0;
      r_core_wdog <= (r_core_state == C_RUN) ? r_core_wdog + 32'd1 : '0;
    end
  end

  assign w_gen_tmo  = (r_gen_state == G_RUN)  && (r_gen_wdog == WDOG_LAST);
  assign w_core_tmo = (r_core_state == C_RUN) && (r_core_wdog == WDOG_LAST);
`else
  // WDOG_CYCLES has no effect in this build; both stages wait indefinitely.
  assign w_gen_tmo  = 1'b0 & (WDOG_CYCLES == 0);
  assign w_core_tmo = 1'b0;
`endif

  mc_rr_select #(.N(N_GEN)) u_mu_sel (
    .i_clk   (CLK),
    .i_rst_n (iRstN),
    .i_clr   (~w_busy_mu_next),
    .i_inc   (r_busy_mu),
    .o_sel   (oMuSel)
  );

  mc_rr_select #(.N(N_GEN)) u_sigma_sel (
    .i_clk   (CLK),
    .i_rst_n (iRstN),
    .i_clr   (~w_busy_sig_next),
    .i_inc   (r_busy_sig),
    .o_sel   (oSigmaSel)
  );

  assign oOptReady      = r_opt_ready;
  assign oStartExpMu    = r_start_mu;
  assign oStartExpSigma = r_start_sig;
  assign oBusyExpMu     = r_busy_mu;
  assign oBusyExpSigma  = r_busy_sig;
  assign oSwitch        = r_switch;
  assign oStartCores    = r_start_cores;
  assign oBusyCores     = r_busy_cores;
  assign oResultValid   = r_result_valid;
  assign oResultBank    = r_bank;
  assign oError         = r_error;

endmodule
